// File: rtl/id_stage_hazard.sv
// Decode stage: register file, EX/MEM/WB operand forwarding and load-use interlock into EX.
// Define ID_STALL_CNT_EN to add the saturating stall_count output.
module id_stage_hazard #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned CTRL_W         = 24,
  parameter bit          MEM_LOAD_STALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_b,
  // IF/ID side
  output logic              id_pipe_ready,
  output logic              id_pipe_flush,
  input  logic              id_pipe_valid,
  input  logic [XLEN-1:0]   id_pipe_pc,
  input  logic [XLEN-1:0]   id_pipe_instruction,
  // external decoder
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              dec_rs1_read,
  input  logic              dec_rs2_read,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic              dec_rd_write,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic [XLEN-1:0]   dec_immediate,
  // ID/EX side
  input  logic              ex_pipe_ready,
  input  logic              ex_pipe_flush,
  output logic              ex_pipe_valid,
  output logic [XLEN-1:0]   ex_pipe_pc,
  output logic [XLEN-1:0]   ex_pipe_instruction,
  output logic [XLEN-1:0]   ex_pipe_immediate,
  output logic [CTRL_W-1:0] ex_pipe_ctrl,
  output logic [XLEN-1:0]   ex_pipe_rs1_rdata,
  output logic [XLEN-1:0]   ex_pipe_rs2_rdata,
  output logic              ex_pipe_rd_write,
  output logic [REG_AW-1:0] ex_pipe_rd_addr,
  // downstream writeback sources
  input  logic              ex_rd_write,
  input  logic              mem_rd_write,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   ex_rd_wdata,
  input  logic [XLEN-1:0]   mem_rd_wdata,
  input  logic [XLEN-1:0]   wb_rd_wdata,
  input  logic              ex_mem_read,
  input  logic              mem_mem_read
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned NumRegs = 1 << REG_AW;

  // Register file: x0 is never written, its reads are masked by forwarding.
  logic [XLEN-1:0] rf_q [NumRegs];

  always_ff @(posedge clk) begin
    if (wb_rd_write && (wb_rd_addr != '0)) begin
      rf_q[wb_rd_addr] <= wb_rd_wdata;
    end
  end

  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_val,
    input logic              ex_w,
    input logic [REG_AW-1:0] ex_a,
    input logic [XLEN-1:0]   ex_d,
    input logic              mem_w,
    input logic [REG_AW-1:0] mem_a,
    input logic [XLEN-1:0]   mem_d,
    input logic              wb_w,
    input logic [REG_AW-1:0] wb_a,
    input logic [XLEN-1:0]   wb_d
  );
    if (addr == '0) return '0;
    if (ex_w && (ex_a == addr)) return ex_d;
    if (mem_w && (mem_a == addr)) return mem_d;
    if (wb_w && (wb_a == addr)) return wb_d;
    return rf_val;
  endfunction

  function automatic logic load_hit(
    input logic              is_load,
    input logic              rd_w,
    input logic [REG_AW-1:0] rd,
    input logic              rs1_rd,
    input logic [REG_AW-1:0] rs1,
    input logic              rs2_rd,
    input logic [REG_AW-1:0] rs2
  );
    return is_load && rd_w && (rd != '0) &&
           ((rs1_rd && (rs1 == rd)) || (rs2_rd && (rs2 == rd)));
  endfunction

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            hz_ex;
  logic            hz_mem;
  logic            stall;
  logic            id_fire;

  always_comb begin
    rs1_fwd = fwd_operand(dec_rs1_addr, rf_q[dec_rs1_addr],
                          ex_rd_write, ex_rd_addr, ex_rd_wdata,
                          mem_rd_write, mem_rd_addr, mem_rd_wdata,
                          wb_rd_write, wb_rd_addr, wb_rd_wdata);
    rs2_fwd = fwd_operand(dec_rs2_addr, rf_q[dec_rs2_addr],
                          ex_rd_write, ex_rd_addr, ex_rd_wdata,
                          mem_rd_write, mem_rd_addr, mem_rd_wdata,
                          wb_rd_write, wb_rd_addr, wb_rd_wdata);
  end

  always_comb begin
    hz_ex  = load_hit(ex_mem_read, ex_rd_write, ex_rd_addr,
                      dec_rs1_read, dec_rs1_addr, dec_rs2_read, dec_rs2_addr);
    // A MEM-stage load only has its data in WB, so optionally wait one more cycle.
    hz_mem = MEM_LOAD_STALL &&
             load_hit(mem_mem_read, mem_rd_write, mem_rd_addr,
                      dec_rs1_read, dec_rs1_addr, dec_rs2_read, dec_rs2_addr);
    // Flush outranks stall: the killed instruction must not hold IF.
    stall         = id_pipe_valid && (hz_ex || hz_mem) && !ex_pipe_flush;
    id_fire       = id_pipe_valid && !ex_pipe_flush && !stall;
    id_pipe_ready = ex_pipe_ready && !stall;
    id_pipe_flush = ex_pipe_flush;
  end

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              rd_write_q;
  logic [REG_AW-1:0] rd_addr_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_write_q <= 1'b0;
      rd_addr_q  <= '0;
    end else if (ex_pipe_ready) begin
      // Payload always loads; valid alone marks a bubble.
      valid_q    <= id_fire;
      pc_q       <= id_pipe_pc;
      instr_q    <= id_pipe_instruction;
      imm_q      <= dec_immediate;
      ctrl_q     <= dec_ctrl;
      rs1_q      <= rs1_fwd;
      rs2_q      <= rs2_fwd;
      rd_write_q <= dec_rd_write;
      rd_addr_q  <= dec_rd_addr;
    end
  end

  assign ex_pipe_valid       = valid_q;
  assign ex_pipe_pc          = pc_q;
  assign ex_pipe_instruction = instr_q;
  assign ex_pipe_immediate   = imm_q;
  assign ex_pipe_ctrl        = ctrl_q;
  assign ex_pipe_rs1_rdata   = rs1_q;
  assign ex_pipe_rs2_rdata   = rs2_q;
  assign ex_pipe_rd_write    = rd_write_q;
  assign ex_pipe_rd_addr     = rd_addr_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt_q <= '0;
    end else if (stall && ex_pipe_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_hazard.sv
// Randomised and directed bench for id_stage_hazard; two instances cover MEM_LOAD_STALL=0 and 1.
// Expected values come from an operand/hazard model built from the stage rules.
module tb_id_stage_hazard;

  logic        clk;
  logic        rst_b;
  logic        id_pipe_valid;
  logic [31:0] id_pipe_pc, id_pipe_instruction;
  logic [23:0] dec_ctrl;
  logic        dec_rs1_read, dec_rs2_read, dec_rd_write;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [31:0] dec_immediate;
  logic        ex_pipe_ready, ex_pipe_flush;
  logic        ex_rd_write, mem_rd_write, wb_rd_write;
  logic [4:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [31:0] ex_rd_wdata, mem_rd_wdata, wb_rd_wdata;
  logic        ex_mem_read, mem_mem_read;

  logic        id_pipe_ready, id_pipe_flush, ex_pipe_valid, ex_pipe_rd_write;
  logic [31:0] ex_pipe_pc, ex_pipe_instruction, ex_pipe_immediate;
  logic [31:0] ex_pipe_rs1_rdata, ex_pipe_rs2_rdata;
  logic [23:0] ex_pipe_ctrl;
  logic [4:0]  ex_pipe_rd_addr;

  logic        m_id_pipe_ready, m_id_pipe_flush, m_ex_pipe_valid, m_ex_pipe_rd_write;
  logic [31:0] m_ex_pipe_pc, m_ex_pipe_instruction, m_ex_pipe_immediate;
  logic [31:0] m_ex_pipe_rs1_rdata, m_ex_pipe_rs2_rdata;
  logic [23:0] m_ex_pipe_ctrl;
  logic [4:0]  m_ex_pipe_rd_addr;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_count, m_stall_count;
`endif

  id_stage_hazard #(.MEM_LOAD_STALL(1'b0)) u_dut (
    .clk(clk), .rst_b(rst_b),
    .id_pipe_ready(id_pipe_ready), .id_pipe_flush(id_pipe_flush),
    .id_pipe_valid(id_pipe_valid), .id_pipe_pc(id_pipe_pc),
    .id_pipe_instruction(id_pipe_instruction), .dec_ctrl(dec_ctrl),
    .dec_rs1_read(dec_rs1_read), .dec_rs2_read(dec_rs2_read),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_write(dec_rd_write), .dec_rd_addr(dec_rd_addr), .dec_immediate(dec_immediate),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_flush(ex_pipe_flush),
    .ex_pipe_valid(ex_pipe_valid), .ex_pipe_pc(ex_pipe_pc),
    .ex_pipe_instruction(ex_pipe_instruction), .ex_pipe_immediate(ex_pipe_immediate),
    .ex_pipe_ctrl(ex_pipe_ctrl), .ex_pipe_rs1_rdata(ex_pipe_rs1_rdata),
    .ex_pipe_rs2_rdata(ex_pipe_rs2_rdata), .ex_pipe_rd_write(ex_pipe_rd_write),
    .ex_pipe_rd_addr(ex_pipe_rd_addr),
    .ex_rd_write(ex_rd_write), .mem_rd_write(mem_rd_write), .wb_rd_write(wb_rd_write),
    .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .ex_rd_wdata(ex_rd_wdata), .mem_rd_wdata(mem_rd_wdata), .wb_rd_wdata(wb_rd_wdata),
    .ex_mem_read(ex_mem_read), .mem_mem_read(mem_mem_read)
`ifdef ID_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  id_stage_hazard #(.MEM_LOAD_STALL(1'b1)) u_dut_m (
    .clk(clk), .rst_b(rst_b),
    .id_pipe_ready(m_id_pipe_ready), .id_pipe_flush(m_id_pipe_flush),
    .id_pipe_valid(id_pipe_valid), .id_pipe_pc(id_pipe_pc),
    .id_pipe_instruction(id_pipe_instruction), .dec_ctrl(dec_ctrl),
    .dec_rs1_read(dec_rs1_read), .dec_rs2_read(dec_rs2_read),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_write(dec_rd_write), .dec_rd_addr(dec_rd_addr), .dec_immediate(dec_immediate),
    .ex_pipe_ready(ex_pipe_ready), .ex_pipe_flush(ex_pipe_flush),
    .ex_pipe_valid(m_ex_pipe_valid), .ex_pipe_pc(m_ex_pipe_pc),
    .ex_pipe_instruction(m_ex_pipe_instruction), .ex_pipe_immediate(m_ex_pipe_immediate),
    .ex_pipe_ctrl(m_ex_pipe_ctrl), .ex_pipe_rs1_rdata(m_ex_pipe_rs1_rdata),
    .ex_pipe_rs2_rdata(m_ex_pipe_rs2_rdata), .ex_pipe_rd_write(m_ex_pipe_rd_write),
    .ex_pipe_rd_addr(m_ex_pipe_rd_addr),
    .ex_rd_write(ex_rd_write), .mem_rd_write(mem_rd_write), .wb_rd_write(wb_rd_write),
    .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .ex_rd_wdata(ex_rd_wdata), .mem_rd_wdata(mem_rd_wdata), .wb_rd_wdata(wb_rd_wdata),
    .ex_mem_read(ex_mem_read), .mem_mem_read(mem_mem_read)
`ifdef ID_STALL_CNT_EN
    , .stall_count(m_stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  // Architectural register state as seen after each WB write.
  logic [31:0] rf_m [32];

  // Expected EX register contents (shared payload, per-instance valid).
  logic        e_valid, e_valid_m, e_rdw;
  logic [31:0] e_pc, e_instr, e_imm, e_rs1, e_rs2;
  logic [23:0] e_ctrl;
  logic [4:0]  e_rda;
  logic [31:0] e_cnt, e_cnt_m;

  // Youngest producer wins; x0 is hardwired zero.
  function automatic logic [31:0] model_operand(input logic [4:0] a);
    logic        w [3];
    logic [4:0]  ad [3];
    logic [31:0] d [3];
    w  = '{ex_rd_write, mem_rd_write, wb_rd_write};
    ad = '{ex_rd_addr, mem_rd_addr, wb_rd_addr};
    d  = '{ex_rd_wdata, mem_rd_wdata, wb_rd_wdata};
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++) if (w[i] && ad[i] == a) return d[i];
    return rf_m[a];
  endfunction

  // Stall if any in-flight load (EX, plus MEM when enabled) produces a source ID needs.
  function automatic bit model_stall(input bit mem_too);
    bit         ld [2];
    logic [4:0] rd [2];
    bit         hit;
    ld  = '{ex_mem_read && ex_rd_write, mem_too && mem_mem_read && mem_rd_write};
    rd  = '{ex_rd_addr, mem_rd_addr};
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (ld[i] && rd[i] != 5'd0 &&
          ((dec_rs1_read && dec_rs1_addr == rd[i]) || (dec_rs2_read && dec_rs2_addr == rd[i])))
        hit = 1'b1;
    return id_pipe_valid && hit && !ex_pipe_flush;
  endfunction

  task automatic clear_model();
    e_valid = 0; e_valid_m = 0; e_rdw = 0; e_pc = 0; e_instr = 0; e_imm = 0;
    e_rs1 = 0; e_rs2 = 0; e_ctrl = 0; e_rda = 0; e_cnt = 0; e_cnt_m = 0;
  endtask

  task automatic idle();
    id_pipe_valid = 0; id_pipe_pc = 0; id_pipe_instruction = 0; dec_ctrl = 0;
    dec_rs1_read = 0; dec_rs2_read = 0; dec_rs1_addr = 0; dec_rs2_addr = 0;
    dec_rd_write = 0; dec_rd_addr = 0; dec_immediate = 0;
    ex_pipe_ready = 1; ex_pipe_flush = 0;
    ex_rd_write = 0; mem_rd_write = 0; wb_rd_write = 0;
    ex_rd_addr = 0; mem_rd_addr = 0; wb_rd_addr = 0;
    ex_rd_wdata = 0; mem_rd_wdata = 0; wb_rd_wdata = 0;
    ex_mem_read = 0; mem_mem_read = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input bit r1, input logic [4:0] a1,
                       input bit r2, input logic [4:0] a2);
    id_pipe_valid = 1; id_pipe_pc = pc; id_pipe_instruction = pc ^ 32'hA5A5_0000;
    dec_ctrl = pc[23:0]; dec_immediate = ~pc; dec_rd_write = 1; dec_rd_addr = pc[6:2];
    dec_rs1_read = r1; dec_rs1_addr = a1; dec_rs2_read = r2; dec_rs2_addr = a2;
  endtask

  // Predict the EX registers for the coming edge, clock it, then retire the WB write.
  task automatic advance();
    bit st, st_m;
    st   = model_stall(1'b0);
    st_m = model_stall(1'b1);
    if (ex_pipe_ready) begin
      e_valid   = id_pipe_valid && !ex_pipe_flush && !st;
      e_valid_m = id_pipe_valid && !ex_pipe_flush && !st_m;
      e_pc = id_pipe_pc; e_instr = id_pipe_instruction; e_imm = dec_immediate;
      e_ctrl = dec_ctrl; e_rdw = dec_rd_write; e_rda = dec_rd_addr;
      e_rs1 = model_operand(dec_rs1_addr); e_rs2 = model_operand(dec_rs2_addr);
      if (st && e_cnt != 32'hFFFF_FFFF) e_cnt++;
      if (st_m && e_cnt_m != 32'hFFFF_FFFF) e_cnt_m++;
    end
    @(posedge clk);
    #1;
    if (wb_rd_write && wb_rd_addr != 5'd0) rf_m[wb_rd_addr] = wb_rd_wdata;
  endtask

  task automatic test_reset();
    idle();
    clear_model();
    rst_b = 0;
    #12;
    n_checks++; if (ex_pipe_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", ex_pipe_valid); end
    n_checks++; if (ex_pipe_pc !== 32'd0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", ex_pipe_pc); end
    n_checks++; if (ex_pipe_ctrl !== 24'd0) begin n_errors++; $display("FAIL reset_ctrl: got %h want 0", ex_pipe_ctrl); end
    n_checks++; if (ex_pipe_rs1_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rs1: got %h want 0", ex_pipe_rs1_rdata); end
`ifdef ID_STALL_CNT_EN
    n_checks++; if (stall_count !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
`endif
    @(posedge clk);
    #1 rst_b = 1;
  endtask

  task automatic init_rf();
    rf_m[0] = 0;
    for (int r = 1; r < 32; r++) begin
      wb_rd_write = 1; wb_rd_addr = 5'(r); wb_rd_wdata = 32'h1000_0000 + 32'(r) * 32'h111;
      advance();
    end
    idle();
  endtask

  task automatic test_forward_alu();
    idle();
    ex_rd_write = 1; ex_rd_addr = 5; ex_rd_wdata = 32'h1234;
    instr(32'h40, 1, 5, 0, 0);
    #1;
    n_checks++; if (id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL alu_ready: got %b want 1", id_pipe_ready); end
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL alu_valid: got %b want 1", ex_pipe_valid); end
    n_checks++; if (ex_pipe_rs1_rdata !== 32'h1234) begin n_errors++; $display("FAIL alu_fwd: got %h want 00001234", ex_pipe_rs1_rdata); end
    n_checks++; if (ex_pipe_pc !== 32'h40) begin n_errors++; $display("FAIL alu_pc: got %h want 00000040", ex_pipe_pc); end
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1; ex_rd_write = 1; ex_rd_addr = 7; ex_rd_wdata = 32'hBAD0;
    instr(32'h80, 0, 0, 1, 7);
    #1;
    n_checks++; if (id_pipe_ready !== 1'b0) begin n_errors++; $display("FAIL lu_ready: got %b want 0", id_pipe_ready); end
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b0) begin n_errors++; $display("FAIL lu_bubble: got %b want 0", ex_pipe_valid); end
    ex_mem_read = 0; ex_rd_write = 0; ex_rd_addr = 0;
    mem_mem_read = 1; mem_rd_write = 1; mem_rd_addr = 7; mem_rd_wdata = 32'hCAFE;
    #1;
    n_checks++; if (id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL lu_release: got %b want 1", id_pipe_ready); end
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL lu_valid: got %b want 1", ex_pipe_valid); end
    n_checks++; if (ex_pipe_rs2_rdata !== 32'hCAFE) begin n_errors++; $display("FAIL lu_fwd: got %h want 0000cafe", ex_pipe_rs2_rdata); end
`ifdef ID_STALL_CNT_EN
    n_checks++; if (stall_count !== e_cnt) begin n_errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_count, e_cnt); end
`endif
  endtask

  task automatic test_mem_load_stall();
    idle();
    ex_mem_read = 1; ex_rd_write = 1; ex_rd_addr = 3;
    instr(32'hC0, 1, 3, 0, 0);
    #1;
    n_checks++; if (m_id_pipe_ready !== 1'b0) begin n_errors++; $display("FAIL ml_stall1: got %b want 0", m_id_pipe_ready); end
    advance();
    ex_mem_read = 0; ex_rd_write = 0; ex_rd_addr = 0;
    mem_mem_read = 1; mem_rd_write = 1; mem_rd_addr = 3; mem_rd_wdata = 32'hDEAD;
    #1;
    n_checks++; if (m_id_pipe_ready !== 1'b0) begin n_errors++; $display("FAIL ml_stall2: got %b want 0", m_id_pipe_ready); end
    n_checks++; if (id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL ml_nostall_p0: got %b want 1", id_pipe_ready); end
    advance();
    n_checks++; if (m_ex_pipe_valid !== 1'b0) begin n_errors++; $display("FAIL ml_bubble: got %b want 0", m_ex_pipe_valid); end
    mem_mem_read = 0; mem_rd_write = 0; mem_rd_addr = 0;
    wb_rd_write = 1; wb_rd_addr = 3; wb_rd_wdata = 32'h3333;
    #1;
    n_checks++; if (m_id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL ml_release: got %b want 1", m_id_pipe_ready); end
    advance();
    n_checks++; if (m_ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL ml_valid: got %b want 1", m_ex_pipe_valid); end
    n_checks++; if (m_ex_pipe_rs1_rdata !== 32'h3333) begin n_errors++; $display("FAIL ml_wbfwd: got %h want 00003333", m_ex_pipe_rs1_rdata); end
  endtask

  task automatic test_priority_x0();
    idle();
    ex_rd_write = 1; ex_rd_addr = 9; ex_rd_wdata = 1;
    mem_rd_write = 1; mem_rd_addr = 9; mem_rd_wdata = 2;
    wb_rd_write = 1; wb_rd_addr = 9; wb_rd_wdata = 3;
    instr(32'h100, 1, 9, 1, 9);
    advance();
    n_checks++; if (ex_pipe_rs1_rdata !== 32'd1) begin n_errors++; $display("FAIL prio_rs1: got %h want 1", ex_pipe_rs1_rdata); end
    idle();
    ex_mem_read = 1; ex_rd_write = 1; ex_rd_addr = 0; ex_rd_wdata = 32'h55;
    instr(32'h104, 1, 0, 1, 0);
    #1;
    n_checks++; if (id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL x0_nostall: got %b want 1", id_pipe_ready); end
    advance();
    n_checks++; if (ex_pipe_rs1_rdata !== 32'd0) begin n_errors++; $display("FAIL x0_rs1: got %h want 0", ex_pipe_rs1_rdata); end
    n_checks++; if (ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL x0_valid: got %b want 1", ex_pipe_valid); end
    // x9 was written by WB above: the regfile path must now return 3.
    idle();
    instr(32'h108, 1, 9, 0, 0);
    advance();
    n_checks++; if (ex_pipe_rs1_rdata !== 32'd3) begin n_errors++; $display("FAIL rf_read: got %h want 3", ex_pipe_rs1_rdata); end
  endtask

  task automatic test_flush_stall();
    logic [31:0] cnt_before;
    idle();
`ifdef ID_STALL_CNT_EN
    cnt_before = stall_count;
`else
    cnt_before = 0;
`endif
    ex_mem_read = 1; ex_rd_write = 1; ex_rd_addr = 4; ex_pipe_flush = 1;
    instr(32'h140, 1, 4, 0, 0);
    #1;
    n_checks++; if (id_pipe_ready !== 1'b1) begin n_errors++; $display("FAIL fl_ready: got %b want 1", id_pipe_ready); end
    n_checks++; if (id_pipe_flush !== 1'b1) begin n_errors++; $display("FAIL fl_flush: got %b want 1", id_pipe_flush); end
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b0) begin n_errors++; $display("FAIL fl_valid: got %b want 0", ex_pipe_valid); end
`ifdef ID_STALL_CNT_EN
    n_checks++; if (stall_count !== cnt_before) begin n_errors++; $display("FAIL fl_cnt: got %0d want %0d", stall_count, cnt_before); end
`endif
    ex_pipe_ready = 0;
    #1;
    n_checks++; if (id_pipe_ready !== 1'b0) begin n_errors++; $display("FAIL fl_ready_follow: got %b want 0", id_pipe_ready); end
    advance();
    n_checks++; if (ex_pipe_pc !== 32'h140) begin n_errors++; $display("FAIL hold_pc: got %h want 00000140 (cnt0 %0d)", ex_pipe_pc, cnt_before); end
  endtask

  task automatic test_reset_midstream();
    idle();
    instr(32'h200, 1, 2, 0, 0);
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL mr_pre: got %b want 1", ex_pipe_valid); end
    #3 rst_b = 0;
    #1;
    n_checks++; if (ex_pipe_valid !== 1'b0) begin n_errors++; $display("FAIL mr_valid: got %b want 0", ex_pipe_valid); end
    n_checks++; if (ex_pipe_pc !== 32'd0) begin n_errors++; $display("FAIL mr_pc: got %h want 0", ex_pipe_pc); end
    n_checks++; if (m_ex_pipe_rs1_rdata !== 32'd0) begin n_errors++; $display("FAIL mr_rs1: got %h want 0", m_ex_pipe_rs1_rdata); end
    clear_model();
    idle();
    #2 rst_b = 1;
    advance();
    instr(32'h240, 1, 6, 0, 0);
    advance();
    n_checks++; if (ex_pipe_valid !== 1'b1) begin n_errors++; $display("FAIL mr_post_valid: got %b want 1", ex_pipe_valid); end
    n_checks++; if (ex_pipe_pc !== 32'h240) begin n_errors++; $display("FAIL mr_post_pc: got %h want 00000240", ex_pipe_pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_pipe_valid = ($urandom_range(0, 9) < 8);
      id_pipe_pc = $urandom(); id_pipe_instruction = $urandom(); dec_immediate = $urandom();
      dec_ctrl = 24'($urandom());
      dec_rs1_read = $urandom_range(0, 1); dec_rs2_read = $urandom_range(0, 1);
      dec_rs1_addr = 5'($urandom_range(0, 7)); dec_rs2_addr = 5'($urandom_range(0, 7));
      dec_rd_write = $urandom_range(0, 1); dec_rd_addr = 5'($urandom_range(0, 31));
      ex_pipe_ready = ($urandom_range(0, 9) < 8); ex_pipe_flush = ($urandom_range(0, 9) == 0);
      ex_rd_write = $urandom_range(0, 1); ex_rd_addr = 5'($urandom_range(0, 7));
      mem_rd_write = $urandom_range(0, 1); mem_rd_addr = 5'($urandom_range(0, 7));
      wb_rd_write = $urandom_range(0, 1); wb_rd_addr = 5'($urandom_range(0, 7));
      ex_rd_wdata = $urandom(); mem_rd_wdata = $urandom(); wb_rd_wdata = $urandom();
      ex_mem_read = ($urandom_range(0, 2) == 0); mem_mem_read = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++; if (id_pipe_ready !== (ex_pipe_ready && !model_stall(1'b0))) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b", n, id_pipe_ready); end
      n_checks++; if (m_id_pipe_ready !== (ex_pipe_ready && !model_stall(1'b1))) begin n_errors++; $display("FAIL rnd_ready_m[%0d]: got %b", n, m_id_pipe_ready); end
      n_checks++; if (id_pipe_flush !== ex_pipe_flush) begin n_errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, id_pipe_flush, ex_pipe_flush); end
      advance();
      n_checks++; if (ex_pipe_valid !== e_valid) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ex_pipe_valid, e_valid); end
      n_checks++; if (m_ex_pipe_valid !== e_valid_m) begin n_errors++; $display("FAIL rnd_valid_m[%0d]: got %b want %b", n, m_ex_pipe_valid, e_valid_m); end
      n_checks++; if (ex_pipe_rs1_rdata !== e_rs1) begin n_errors++; $display("FAIL rnd_rs1[%0d]: got %h want %h", n, ex_pipe_rs1_rdata, e_rs1); end
      n_checks++; if (ex_pipe_rs2_rdata !== e_rs2) begin n_errors++; $display("FAIL rnd_rs2[%0d]: got %h want %h", n, ex_pipe_rs2_rdata, e_rs2); end
      n_checks++; if (m_ex_pipe_rs1_rdata !== e_rs1) begin n_errors++; $display("FAIL rnd_rs1_m[%0d]: got %h want %h", n, m_ex_pipe_rs1_rdata, e_rs1); end
      n_checks++; if ({ex_pipe_pc, ex_pipe_instruction, ex_pipe_immediate} !== {e_pc, e_instr, e_imm}) begin n_errors++; $display("FAIL rnd_payload[%0d]: got %h/%h/%h want %h/%h/%h", n, ex_pipe_pc, ex_pipe_instruction, ex_pipe_immediate, e_pc, e_instr, e_imm); end
      n_checks++; if ({ex_pipe_ctrl, ex_pipe_rd_write, ex_pipe_rd_addr} !== {e_ctrl, e_rdw, e_rda}) begin n_errors++; $display("FAIL rnd_ctrl[%0d]: got %h/%b/%0d want %h/%b/%0d", n, ex_pipe_ctrl, ex_pipe_rd_write, ex_pipe_rd_addr, e_ctrl, e_rdw, e_rda); end
`ifdef ID_STALL_CNT_EN
      n_checks++; if (stall_count !== e_cnt) begin n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, stall_count, e_cnt); end
      n_checks++; if (m_stall_count !== e_cnt_m) begin n_errors++; $display("FAIL rnd_cnt_m[%0d]: got %0d want %0d", n, m_stall_count, e_cnt_m); end
`endif
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    init_rf();
    test_forward_alu();
    test_load_use();
    test_mem_load_stall();
    test_priority_x0();
    test_flush_stall();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
